// File: rtl/mdv_pkg.sv
// mdv_pkg: shared types and constants for the microdrive write path.
// Holds the write FSM state encoding, the preamble byte values and the
// default cartridge word-address width shared with the playback engine.
package mdv_pkg;
    typedef enum logic [1:0] {IDLE, SYNC, SYNC_FF, DATA} mdv_state_e;
    localparam logic [7:0] MDV_PRE_ZERO = 8'h00;
    localparam logic [7:0] MDV_PRE_SYNC = 8'hFF;
    localparam int MDV_ADDR_W = 17;
endpackage

// File: rtl/mdv_writer_if.sv
// mdv_writer_if: word write port into the cartridge image buffer.
//   mem_wr    one-clk word write strobe
//   mem_addr  word address
//   mem_data  {first byte, second byte}
// master: the writer drives the port; slave: the cartridge RAM side.
interface mdv_writer_if import mdv_pkg::*; #(parameter int ADDR_W = MDV_ADDR_W);
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    modport master (output mem_wr, mem_addr, mem_data);
    modport slave  (input  mem_wr, mem_addr, mem_data);
endinterface

// File: rtl/mdv_tx_reg.sv
// mdv_tx_reg: transmit holding register paced at tape byte rate.
//   clk, reset       clock, async active-high reset
//   ce               clock enable that advances the byte timer
//   active, start    write path running / first cycle of a block
//   tx_wr, tx_data   CPU write into the holding register
//   tx_empty         holding register free
//   underrun         sticky: a slot passed with nothing to send
//   byte_valid       one-clk: rx_byte consumed this cycle
//   rx_byte          holding register contents
module mdv_tx_reg #(parameter int BYTE_TICKS = 640) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       active,
    input  logic       start,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_empty,
    output logic       underrun,
    output logic       byte_valid,
    output logic [7:0] rx_byte
);
    localparam int TW = $clog2(BYTE_TICKS);
    logic [TW-1:0] timer;
    logic          slot;
    // The rise cycle only loads the timer, so the first slot lands BYTE_TICKS ce ticks later.
    assign slot       = active && !start && ce && timer == '0;
    assign byte_valid = slot && !tx_empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            tx_empty <= 1'b1;
            underrun <= 1'b0;
            rx_byte  <= '0;
        end else begin
            if (start)
                timer <= TW'(BYTE_TICKS - 1);
            else if (active && ce)
                timer <= timer == '0 ? TW'(BYTE_TICKS - 1) : timer - 1'b1;
            if (tx_wr)
                rx_byte <= tx_data;
            // A write in the slot cycle refills the register the slot just drained.
            tx_empty <= !tx_wr && (tx_empty || slot);
            underrun <= !start && (underrun || (slot && tx_empty));
        end
    end
endmodule

// File: rtl/mdv_writer.sv
// mdv_writer: microdrive write path into the cartridge image buffer.
//   clk, reset       clock, async active-high reset
//   ce               bus clock enable pacing the byte timer
//   sel, wr_en       drive selected / write enabled; both high = active
//   tx_wr, tx_data   CPU write to the transmit register
//   pos              tape word position, latched at block start
//   tx_empty         holding register free
//   underrun         sticky byte-slot underrun
//   dirty, dirty_clr image modified flag and its clear
//   mem              word write port (master)
module mdv_writer import mdv_pkg::*; #(
    parameter int BYTE_TICKS = 640,
    parameter int ADDR_W     = MDV_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              sel,
    input  logic              wr_en,
    input  logic              tx_wr,
    input  logic [7:0]        tx_data,
    input  logic [ADDR_W-1:0] pos,
    output logic              tx_empty,
    output logic              underrun,
    output logic              dirty,
    input  logic              dirty_clr,
    mdv_writer_if.master      mem
);
    mdv_state_e        state;
    logic              active, active_q, start, byte_valid, pend;
    logic [7:0]        rx_byte, hi;
    logic [ADDR_W-1:0] base, idx, waddr, addr_q;
    logic              wr_q;
    logic [15:0]       data_q;

    assign active = sel && wr_en;
    assign start  = active && !active_q;
    assign waddr  = base + idx;
    assign mem.mem_wr   = wr_q;
    assign mem.mem_addr = addr_q;
    assign mem.mem_data = data_q;

    mdv_tx_reg #(.BYTE_TICKS(BYTE_TICKS)) u_tx (
        .clk(clk), .reset(reset), .ce(ce), .active(active), .start(start),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_empty(tx_empty),
        .underrun(underrun), .byte_valid(byte_valid), .rx_byte(rx_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            active_q <= 1'b0;
            base     <= '0;
            idx      <= '0;
            hi       <= '0;
            pend     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            dirty    <= 1'b0;
        end else begin
            active_q <= active;
            wr_q     <= 1'b0;
            // wr_q is the strobe currently on the port, so a same-cycle clear loses.
            dirty    <= wr_q || (dirty && !dirty_clr);
            if (!active) begin
                // pend is cleared here, so the flush fires only on the falling edge.
                if (state == DATA && pend) begin
                    wr_q   <= 1'b1;
                    addr_q <= waddr;
                    data_q <= {hi, 8'h00};
                end
                state <= IDLE;
                pend  <= 1'b0;
            end else if (!active_q) begin
                base  <= pos;
                idx   <= '0;
                pend  <= 1'b0;
                state <= SYNC;
            end else if (byte_valid) begin
                state <= state == SYNC    ? (rx_byte == MDV_PRE_SYNC ? SYNC_FF : SYNC) :
                         state == SYNC_FF ? (rx_byte == MDV_PRE_SYNC ? DATA : SYNC) : state;
                if (state == DATA) begin
                    pend <= !pend;
                    hi   <= rx_byte;
                    if (pend) begin
                        wr_q   <= 1'b1;
                        addr_q <= waddr;
                        data_q <= {hi, rx_byte};
                        idx    <= idx + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mdv_writer.sv
// tb_mdv_writer: table-driven blocks, hand sequences and random traffic for mdv_writer.
module tb_mdv_writer;
    localparam int BT = 10;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset, ce, sel, wr_en, tx_wr, dirty_clr;
    logic [7:0]    tx_data;
    logic [AW-1:0] pos;
    logic          tx_empty, underrun, dirty;

    mdv_writer_if #(.ADDR_W(AW)) mem_if ();

    mdv_writer #(.BYTE_TICKS(BT), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .sel(sel), .wr_en(wr_en),
        .tx_wr(tx_wr), .tx_data(tx_data), .pos(pos), .tx_empty(tx_empty),
        .underrun(underrun), .dirty(dirty), .dirty_clr(dirty_clr), .mem(mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tick count since block start, run of preamble FFs, and a byte queue.
    bit            m_prev, m_full;
    logic [7:0]    m_hold;
    int            m_ticks, m_ff;
    logic [AW-1:0] m_base, m_idx;
    logic [7:0]    m_q[$];
    bit            e_tx_empty, e_underrun, e_mem_wr, e_dirty;
    logic [AW-1:0] e_addr;
    logic [15:0]   e_data;
    bit            ce_rand = 1'b1;

    typedef struct { logic [AW-1:0] a; logic [15:0] d; } wr_t;
    wr_t cap[$];

    task automatic model_reset();
        m_prev = 0; m_full = 0; m_hold = '0; m_ticks = 0; m_ff = 0; m_q.delete();
        m_base = '0; m_idx = '0;
        e_tx_empty = 1; e_underrun = 0; e_mem_wr = 0; e_dirty = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_step();
        bit act, slot, wr, nd;
        logic [AW-1:0] a;
        logic [15:0] d;
        act = sel && wr_en; slot = 0; wr = 0; a = e_addr; d = e_data;
        nd = e_mem_wr || (e_dirty && !dirty_clr);
        if (act && !m_prev) begin
            m_ticks = 0; m_ff = 0; m_q.delete(); m_base = pos; m_idx = '0; e_underrun = 0;
        end else if (act && ce) begin
            m_ticks++;
            slot = (m_ticks % BT) == 0;
        end
        if (!act && m_prev && m_q.size() == 1) begin
            wr = 1; a = m_base + m_idx; d = {m_q[0], 8'h00};
        end
        if (!act) m_q.delete();
        if (slot && !m_full) e_underrun = 1;
        if (slot && m_full) begin
            if (m_ff < 2) m_ff = (m_hold == 8'hFF) ? m_ff + 1 : 0;
            else begin
                m_q.push_back(m_hold);
                if (m_q.size() == 2) begin
                    wr = 1; a = m_base + m_idx; d = {m_q[0], m_q[1]};
                    m_idx++; m_q.delete();
                end
            end
        end
        if (tx_wr) begin m_full = 1; m_hold = tx_data; end
        else if (slot) m_full = 0;
        e_tx_empty = !m_full; e_mem_wr = wr; e_addr = a; e_data = d; e_dirty = nd; m_prev = act;
    endtask

    task automatic compare_all();
        check("tx_empty", tx_empty, e_tx_empty);
        check("underrun", underrun, e_underrun);
        check("mem_wr", mem_if.mem_wr, e_mem_wr);
        check("mem_addr", mem_if.mem_addr, e_addr);
        check("mem_data", mem_if.mem_data, e_data);
        check("dirty", dirty, e_dirty);
    endtask

    task automatic step();
        if (ce_rand) ce = $urandom_range(0, 4) != 0;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (mem_if.mem_wr) cap.push_back('{mem_if.mem_addr, mem_if.mem_data});
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (!tx_empty && n < BT * 8) begin step(); n++; end
        check("byte_consumed", tx_empty, 1);
    endtask

    task automatic feed(input logic [7:0] b);
        tx_wr = 1; tx_data = b; step(); tx_wr = 0;
        wait_empty();
    endtask

    task automatic do_reset();
        #2 reset = 1;
        model_reset();
        #2 compare_all();
        reset = 0;
    endtask

    typedef struct {
        logic [AW-1:0] pos;
        int            nb;
        logic [127:0]  s;
        int            nw;
        logic [AW-1:0] a0, a1;
        logic [15:0]   d0, d1;
    } vec_t;
    vec_t tbl[7];

    task automatic run_block(input int k);
        dirty_clr = 1; step(); dirty_clr = 0;
        cap.delete();
        pos = tbl[k].pos; sel = 1; wr_en = 1; step();
        pos = AW'($urandom);
        for (int i = 0; i < tbl[k].nb; i++) feed(tbl[k].s[8 * (tbl[k].nb - 1 - i) +: 8]);
        step();
        wr_en = 0; step(); step();
        check("blk_nwrites", cap.size(), tbl[k].nw);
        if (tbl[k].nw > 0 && cap.size() > 0) begin
            check("blk_addr0", cap[0].a, tbl[k].a0);
            check("blk_data0", cap[0].d, tbl[k].d0);
        end
        if (tbl[k].nw > 1 && cap.size() > 1) begin
            check("blk_addr1", cap[1].a, tbl[k].a1);
            check("blk_data1", cap[1].d, tbl[k].d1);
        end
        check("blk_dirty", dirty, tbl[k].nw > 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r;
        tbl[0] = '{17'h00100, 16, 128'h00000000000000000000FFFF12345678, 2, 17'h00100, 17'h00101, 16'h1234, 16'h5678};
        tbl[1] = '{17'h02000, 4, 128'h00FFFFAB, 1, 17'h02000, 17'h0, 16'hAB00, 16'h0};
        tbl[2] = '{17'h00040, 8, 128'h00FF5A00FFFF1122, 1, 17'h00040, 17'h0, 16'h1122, 16'h0};
        tbl[3] = '{17'h1FFFF, 6, 128'hFFFF01020304, 2, 17'h1FFFF, 17'h00000, 16'h0102, 16'h0304};
        tbl[4] = '{17'h00005, 6, 128'hFFFFFFFFFFFF, 2, 17'h00005, 17'h00006, 16'hFFFF, 16'hFFFF};
        tbl[5] = '{17'h00010, 6, 128'hFF00FFFF0000, 1, 17'h00010, 17'h0, 16'h0000, 16'h0};
        tbl[6] = '{17'h00ABC, 5, 128'hFFFF010203, 2, 17'h00ABC, 17'h00ABD, 16'h0102, 16'h0300};

        reset = 1; ce = 0; sel = 0; wr_en = 0; tx_wr = 0; tx_data = '0; pos = '0; dirty_clr = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_tx_empty", tx_empty, 1);
        check("rst_underrun", underrun, 0);
        check("rst_mem_wr", mem_if.mem_wr, 0);
        check("rst_mem_addr", mem_if.mem_addr, 0);
        check("rst_mem_data", mem_if.mem_data, 0);
        check("rst_dirty", dirty, 0);
        reset = 0;
        sel = 1;

        // First slot exactly BT ce ticks after the rise.
        ce_rand = 0; ce = 1;
        pos = 17'h00777; wr_en = 1; tx_wr = 1; tx_data = 8'h00; step(); tx_wr = 0;
        repeat (BT - 1) step();
        check("first_slot_wait", tx_empty, 0);
        step();
        check("first_slot", tx_empty, 1);
        ce_rand = 1;
        wr_en = 0; step();

        for (int k = 0; k < 7; k++) run_block(k);

        // Underrun, then overwrite inside one slot: only the later byte is sent.
        cap.delete();
        pos = 17'h00300; wr_en = 1; step();
        pos = AW'($urandom);
        feed(8'hFF); feed(8'hFF);
        n = 0;
        while (!underrun && n < BT * 8) begin step(); n++; end
        check("underrun_set", underrun, 1);
        tx_wr = 1; tx_data = 8'h33; step();
        check("ovw_full1", tx_empty, 0);
        tx_data = 8'h44; step(); tx_wr = 0;
        check("ovw_full2", tx_empty, 0);
        wait_empty();
        feed(8'h55); step();
        check("ovw_nwrites", cap.size(), 1);
        if (cap.size() > 0) begin
            check("ovw_addr", cap[0].a, 17'h00300);
            check("ovw_data", cap[0].d, 16'h4455);
        end
        check("underrun_sticky", underrun, 1);
        wr_en = 0; step();

        // Reset mid-word: nothing written, pending byte and sync are lost.
        pos = 17'h00050; wr_en = 1; step();
        feed(8'hFF); feed(8'hFF); feed(8'hAB);
        do_reset();
        check("midrst_tx_empty", tx_empty, 1);
        check("midrst_mem_wr", mem_if.mem_wr, 0);
        check("midrst_dirty", dirty, 0);
        cap.delete();
        repeat (BT * 3) step();
        feed(8'h12); feed(8'h34); step();
        check("midrst_no_write", cap.size(), 0);
        wr_en = 0; step();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 150) == 0) wr_en = !wr_en;
            if ($urandom_range(0, 400) == 0) sel = !sel;
            tx_wr = $urandom_range(0, BT - 1) == 0;
            r = $urandom_range(0, 3);
            tx_data = r == 0 ? 8'h00 : r == 1 ? 8'hFF : 8'($urandom);
            dirty_clr = $urandom_range(0, 39) == 0;
            pos = AW'($urandom);
            if ($urandom_range(0, 1499) == 0) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdv_writer.md
# mdv_writer

Microdrive write path for the QL core: the transmit side of the cartridge interface whose read side is the existing microdrive playback engine. It accepts bytes the CPU writes to the ZX8302 microdrive transmit register, paces them at tape byte rate, strips the block preamble, and writes byte pairs as 16-bit words into the cartridge image buffer at the current head position. It sits beside the playback engine inside the ZX8302 and shares its cartridge RAM port and its position counter.

## Interface
- BYTE_TICKS, 640: `ce` ticks per tape byte slot.
- ADDR_W, 17: cartridge buffer word-address width.

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- ce  in  1  bus clock enable (`cep`), paces the byte timer
- sel  in  1  drive 1 selected (motor on)
- wr_en  in  1  write-enable bit from the microdrive control register
- tx_wr  in  1  one-clk strobe: CPU wrote the transmit register
- tx_data  in  8  byte written by the CPU
- pos  in  ADDR_W  current tape word position from the playback engine
- tx_empty  out  1  holding register free; reset 1
- underrun  out  1  sticky: byte slot expired with holding register empty; reset 0
- mem_wr  out  1  one-clk word write strobe; reset 0
- mem_addr  out  ADDR_W  word address; reset 0
- mem_data  out  16  {first byte, second byte}; reset 0
- dirty  out  1  image modified since last clear; reset 0
- dirty_clr  in  1  clears `dirty` (OSD save done)

## Operation
- `active` = `sel && wr_en`. Byte timer and state machine run only while `active`.
- Holding register: `tx_wr` loads `tx_data`, sets `tx_empty`=0. `tx_wr` while full overwrites (last write wins).
- Byte timer: loaded with BYTE_TICKS-1 on the rising edge of `active`; decrements on `ce`. On `ce` at 0: slot event, reload. At a slot event:
  - Holding register full: byte consumed, `tx_empty`=1.
  - Holding register empty: `underrun`=1 (cleared only by reset or a new rise of `active`), no byte, state unchanged.
- States:
  - IDLE: `active` low. On the rise of `active`: latch `base`=`pos`, clear word index and `underrun`, go to SYNC.
  - SYNC: consumed 0x00 is discarded. 0xFF goes to SYNC_FF. Any other byte is discarded and the state stays in SYNC.
  - SYNC_FF: 0xFF goes to DATA. 0x00 returns to SYNC. Any other byte returns to SYNC.
  - DATA: an even byte is held as the high byte. An odd byte forms a word; write it to address `base`+index (mod 2^ADDR_W), then index+1.
- Fall of `active` while in DATA with a high byte pending: flush `{hi, 8'h00}`, then IDLE. Fall of `active` in any other state: IDLE. The holding register is unchanged; `tx_empty` stays as is.
- `dirty` is set by every `mem_wr`. `dirty_clr` clears it; if `dirty_clr` and `mem_wr` occur in the same cycle, set wins.
- `reset` mid-block: every output returns to its reset value, the state returns to IDLE, and any pending byte is dropped. No partial word is written.

## Timing
- `tx_wr` in cycle n: `tx_empty`=0 in n+1.
- Slot event in cycle n: `tx_empty`=1 in n+1, unless `tx_wr` also occurs in n. In that case the old byte is consumed, the new byte is loaded, and `tx_empty` stays 0.
- Second byte of a pair consumed in cycle n: `mem_wr`, `mem_addr` and `mem_data` are valid in n+1 for exactly one clk.
- Flush on fall of `active` in cycle n: `mem_wr` in n+1.
- First slot event occurs BYTE_TICKS `ce` ticks after the rise of `active`.
- `pos` is sampled only at the rise of `active`. Later motion of `pos` is ignored for the block.

## Structure
- Package `mdv_pkg`:
  - state enum {IDLE, SYNC, SYNC_FF, DATA}
  - constants MDV_PRE_ZERO=8'h00 and MDV_PRE_SYNC=8'hFF
  - default ADDR_W, shared with the playback engine
- Sub-module `mdv_tx_reg`: holding register, `tx_empty`, byte timer and `underrun`. Outputs a one-clk `byte_valid` with `byte`.
- Top level: sync FSM, word assembly, address arithmetic, `dirty`.

## Test plan
- Basic block: `pos`=0x100, rise `active`, feed 00×10, FF, FF, 12, 34, 56, 78 ahead of each slot. Expect writes 0x1234 @0x100 and 0x5678 @0x101, `dirty`=1.
- Odd flush: after sync, feed AB, then drop `wr_en`. Expect one write 0xAB00 @`base` in the cycle after the fall.
- Bad sync: feed 00, FF, 5A, 00, FF, FF, 11, 22. Expect a single write 0x1122; the 5A is discarded.
- Underrun/overwrite: skip one slot, then write 33 and 44 back-to-back within one slot. Expect `underrun`=1, `tx_empty` staying 0, and only 44 consumed.
- Wrap: `pos`=2^17-1, sync, then 4 data bytes. Expect writes @0x1FFFF and @0x00000.
- Reset mid-word: `reset` pulse after one data byte. Expect no `mem_wr`, `tx_empty`=1, `dirty`=0, IDLE.
